// File: rtl/hv_reader_pkg.sv
// Shared types, output-select encodings and sizing helpers for the class HV reader.
package hv_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_NS,
    SEND_S,
    CHECK,
    FIN
  } state_t;

  localparam logic [1:0] SEL_NS  = 2'd0;
  localparam logic [1:0] SEL_S   = 2'd1;
  localparam logic [1:0] SEL_CHK = 2'd2;

  // Widest word the popcount helper accepts; narrower words are zero-extended.
  localparam int POP_IN_W = 64;

  function automatic int words_per_hv(input int dims, input int word_w);
    return (dims + word_w - 1) / word_w;
  endfunction

  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  function automatic int unsigned popcount(input logic [POP_IN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_IN_W; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/hv_word_sel.sv
// Picks word i_idx out of a hypervector, LSB word first, zero-padding past the top bit.
module hv_word_sel import hv_reader_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int WORD_W     = 32,
  parameter int IDX_W      = cnt_width(words_per_hv(DIMENSIONS, WORD_W))
) (
  input  logic [DIMENSIONS-1:0] i_hv,
  input  logic [IDX_W-1:0]      i_idx,
  output logic [WORD_W-1:0]     o_word
);

  localparam int WORDS = words_per_hv(DIMENSIONS, WORD_W);
  localparam int PAD_W = WORDS * WORD_W;

  logic [PAD_W-1:0] w_padded;

  assign w_padded = PAD_W'(i_hv);
  assign o_word   = w_padded[int'(i_idx)*WORD_W +: WORD_W];

endmodule

// File: rtl/hv_class_reader.sv
// Snapshots the NS/S class hypervectors on start and streams them as valid/ready words.
// Define HV_CHECKSUM_EN to append a popcount checksum word after the S words.
module hv_class_reader import hv_reader_pkg::*; #(
  parameter int DIMENSIONS = 10000,
  parameter int WORD_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIMENSIONS-1:0] ns_hv,
  input  logic [DIMENSIONS-1:0] s_hv,
  output logic                  busy,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_sel,
  output logic                  out_last,
  output logic                  done
);

  localparam int             WORDS    = words_per_hv(DIMENSIONS, WORD_W);
  localparam int             CW       = cnt_width(WORDS);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORDS - 1);

  state_t                r_state, w_next;
  logic [CW-1:0]         r_cnt;
  logic [DIMENSIONS-1:0] r_ns_shadow, r_s_shadow;
  logic [WORD_W-1:0]     w_ns_word, w_s_word;
  logic                  w_accept, w_hs, w_cnt_last;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_hs       = out_valid && out_ready;
  assign w_cnt_last = (r_cnt == LAST_IDX);

  // NOTE: the snapshot is pure data and is never read outside a frame, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ns_shadow <= ns_hv;
      r_s_shadow  <= s_hv;
    end
  end

  hv_word_sel #(.DIMENSIONS(DIMENSIONS), .WORD_W(WORD_W), .IDX_W(CW)) u_ns_sel (
    .i_hv(r_ns_shadow), .i_idx(r_cnt), .o_word(w_ns_word)
  );

  hv_word_sel #(.DIMENSIONS(DIMENSIONS), .WORD_W(WORD_W), .IDX_W(CW)) u_s_sel (
    .i_hv(r_s_shadow), .i_idx(r_cnt), .o_word(w_s_word)
  );

`ifdef HV_CHECKSUM_EN
  localparam int PW   = $clog2(DIMENSIONS + 1);
  localparam int HALF = WORD_W / 2;

  logic [PW-1:0]     r_ns_pop, r_s_pop;
  logic [WORD_W-1:0] w_chk_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ns_pop <= '0;
      r_s_pop  <= '0;
    end else if (w_accept) begin
      r_ns_pop <= '0;
      r_s_pop  <= '0;
    end else if (w_hs && r_state == SEND_NS) begin
      r_ns_pop <= r_ns_pop + PW'(popcount(POP_IN_W'(w_ns_word)));
    end else if (w_hs && r_state == SEND_S) begin
      r_s_pop  <= r_s_pop + PW'(popcount(POP_IN_W'(w_s_word)));
    end
  end

  assign w_chk_word = {(WORD_W - HALF)'(r_s_pop), HALF'(r_ns_pop)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)  r_cnt <= '0;
      else if (w_hs) r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = SEND_NS;
      SEND_NS: if (w_hs && w_cnt_last) w_next = SEND_S;
      SEND_S: begin
        if (w_hs && w_cnt_last) begin
`ifdef HV_CHECKSUM_EN
          w_next = CHECK;
`else
          w_next = FIN;
`endif
        end
      end
`ifdef HV_CHECKSUM_EN
      CHECK:   if (w_hs) w_next = FIN;
`endif
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    busy      = (r_state != IDLE);
    out_valid = 1'b0;
    out_sel   = SEL_NS;
    out_last  = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    case (r_state)
      SEND_NS: begin
        out_valid = 1'b1;
        out_data  = w_ns_word;
      end
      SEND_S: begin
        out_valid = 1'b1;
        out_sel   = SEL_S;
        out_data  = w_s_word;
`ifndef HV_CHECKSUM_EN
        out_last  = w_cnt_last;
`endif
      end
`ifdef HV_CHECKSUM_EN
      CHECK: begin
        out_valid = 1'b1;
        out_sel   = SEL_CHK;
        out_data  = w_chk_word;
        out_last  = 1'b1;
      end
`endif
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hv_class_reader.sv
// Self-checking bench for hv_class_reader: a 10000/32 instance and a 40/16 instance.
module tb_hv_class_reader;

  localparam int A_D = 10000, A_W = 32, A_WORDS = (A_D + A_W - 1) / A_W;
  localparam int B_D = 40,    B_W = 16, B_WORDS = (B_D + B_W - 1) / B_W;
`ifdef HV_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst = 1'b0, a_start = 1'b0, a_ready = 1'b0;
  logic [A_D-1:0] a_ns = '0, a_s = '0;
  logic [A_W-1:0] a_data;
  logic           a_busy, a_valid, a_last, a_done;
  logic [1:0]     a_sel;

  logic           b_rst = 1'b0, b_start = 1'b0, b_ready = 1'b0;
  logic [B_D-1:0] b_ns = '0, b_s = '0;
  logic [B_W-1:0] b_data;
  logic           b_busy, b_valid, b_last, b_done;
  logic [1:0]     b_sel;

  hv_class_reader #(.DIMENSIONS(A_D), .WORD_W(A_W)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .ns_hv(a_ns), .s_hv(a_s),
    .busy(a_busy), .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .out_sel(a_sel), .out_last(a_last), .done(a_done)
  );

  hv_class_reader #(.DIMENSIONS(B_D), .WORD_W(B_W)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .ns_hv(b_ns), .s_hv(b_s),
    .busy(b_busy), .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .out_sel(b_sel), .out_last(b_last), .done(b_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: word k of a vector is simply (hv >> k*W) truncated to W bits.
  logic [A_W-1:0] exp_data[$];
  logic [1:0]     exp_sel[$];
  logic           exp_last[$];

  task automatic build_exp_a(input logic [A_D-1:0] ns, input logic [A_D-1:0] s);
    exp_data.delete(); exp_sel.delete(); exp_last.delete();
    for (int k = 0; k < A_WORDS; k++) begin
      exp_data.push_back(A_W'(ns >> (k * A_W))); exp_sel.push_back(2'd0); exp_last.push_back(1'b0);
    end
    for (int k = 0; k < A_WORDS; k++) begin
      exp_data.push_back(A_W'(s >> (k * A_W))); exp_sel.push_back(2'd1);
      exp_last.push_back(!CHK_EN && (k == A_WORDS - 1));
    end
    if (CHK_EN) begin
      exp_data.push_back({16'($countones(s)), 16'($countones(ns))});
      exp_sel.push_back(2'd2); exp_last.push_back(1'b1);
    end
  endtask

  function automatic logic [A_D-1:0] rand_hv_a();
    logic [A_WORDS*32-1:0] t;
    for (int i = 0; i < A_WORDS; i++) t[i*32 +: 32] = $urandom();
    return A_D'(t);
  endfunction

  task automatic start_a(input logic [A_D-1:0] ns, input logic [A_D-1:0] s);
    @(negedge clk);
    check("a_idle_valid", a_valid, 0);
    a_ns = ns; a_s = s; a_start = 1'b1;
    build_exp_a(ns, s);
  endtask

  // Consumes one frame from dut_a; optionally re-pulses start at NS word 5 or resets at S word rst_at.
  task automatic run_frame_a(input int ready_pct, input bit poke, input int rst_at);
    int idx = 0, guard = 0, early_done = 0;
    bit stalled = 0, poked = 0, was_rst = 0;
    logic [A_W-1:0] h_data = '0;
    logic [1:0]     h_sel = '0;
    logic           h_last = 1'b0;
    while (idx < exp_data.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      a_start = 1'b0;
      if (a_done) early_done++;
      check("frame_valid", a_valid, 1);
      check("frame_busy", a_busy, 1);
      if (stalled) begin
        check("hold_data", a_data, h_data);
        check("hold_sel", a_sel, h_sel);
        check("hold_last", a_last, h_last);
      end
      check("word_data", a_data, exp_data[idx]);
      check("word_sel", a_sel, exp_sel[idx]);
      check("word_last", a_last, exp_last[idx]);
      if (rst_at >= 0 && idx == A_WORDS + rst_at) begin
        a_rst = 1'b1; a_ready = 1'b0; was_rst = 1'b1;
        break;
      end
      if (poke && idx == 5 && !poked) begin
        a_start = 1'b1; a_ns = rand_hv_a(); poked = 1'b1;
      end
      a_ready = ($urandom_range(99) < ready_pct);
      if (a_ready) begin
        idx++; stalled = 1'b0;
      end else begin
        stalled = 1'b1; h_data = a_data; h_sel = a_sel; h_last = a_last;
      end
    end
    check("early_done", early_done, 0);
    if (was_rst) begin
      @(negedge clk);
      a_rst = 1'b0;
      check("rst_valid", a_valid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      @(negedge clk);
      check("rst_done_after", a_done, 0);
    end else begin
      check("frame_len", idx, exp_data.size());
      @(negedge clk);
      a_ready = 1'b0;
      a_start = 1'b0;
      check("done_pulse", a_done, 1);
      check("fin_valid", a_valid, 0);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("done_single", a_done, 0);
        check("post_busy", a_busy, 0);
      end
    end
  endtask

  initial begin
    // Reset both instances and check every output's reset value.
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (2) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("rst_a_busy", a_busy, 0);  check("rst_a_valid", a_valid, 0);
    check("rst_a_data", a_data, 0);  check("rst_a_sel", a_sel, 0);
    check("rst_a_last", a_last, 0);  check("rst_a_done", a_done, 0);
    check("rst_b_busy", b_busy, 0);  check("rst_b_valid", b_valid, 0);
    check("rst_b_data", b_data, 0);  check("rst_b_done", b_done, 0);

    // rst and start together: reset wins.
    a_rst = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_rst = 1'b0; a_start = 1'b0;
    check("rst_start_valid", a_valid, 0);
    check("rst_start_busy", a_busy, 0);

    // NS all zero, S all ones, consumer always ready.
    start_a('0, '1);
    run_frame_a(100, 1'b0, -1);

    // Random vectors with a 50% ready consumer.
    start_a(rand_hv_a(), rand_hv_a());
    run_frame_a(50, 1'b0, -1);

    // Second start plus ns_hv change mid-frame must not disturb the stream.
    start_a(rand_hv_a(), rand_hv_a());
    run_frame_a(100, 1'b1, -1);

    // Reset at S word 10, then a fresh frame from NS word 0.
    start_a(rand_hv_a(), rand_hv_a());
    run_frame_a(70, 1'b0, 10);
    start_a(rand_hv_a(), rand_hv_a());
    run_frame_a(100, 1'b0, -1);

    // Narrow instance: zero padding in the top NS word and one-cycle start latency.
    begin
      logic [B_W-1:0] bq_data[$];
      logic [1:0]     bq_sel[$];
      logic           bq_last[$];
      int idx = 0, guard = 0;
      @(negedge clk);
      b_ns = 40'hA5_1234_5678;
      b_s  = {$urandom(), $urandom()};
      for (int k = 0; k < B_WORDS; k++) begin
        bq_data.push_back(B_W'(b_ns >> (k * B_W))); bq_sel.push_back(2'd0); bq_last.push_back(1'b0);
      end
      for (int k = 0; k < B_WORDS; k++) begin
        bq_data.push_back(B_W'(b_s >> (k * B_W))); bq_sel.push_back(2'd1);
        bq_last.push_back(!CHK_EN && (k == B_WORDS - 1));
      end
      if (CHK_EN) begin
        bq_data.push_back({8'($countones(b_s)), 8'($countones(b_ns))});
        bq_sel.push_back(2'd2); bq_last.push_back(1'b1);
      end
      check("b_pre_valid", b_valid, 0);
      b_start = 1'b1; b_ready = 1'b1;
      while (idx < bq_data.size() && guard < 100) begin
        @(negedge clk);
        guard++;
        b_start = 1'b0;
        check("b_valid", b_valid, 1);
        check("b_data", b_data, bq_data[idx]);
        check("b_sel", b_sel, bq_sel[idx]);
        check("b_last", b_last, bq_last[idx]);
        idx++;
      end
      check("b_frame_len", idx, bq_data.size());
      @(negedge clk);
      b_ready = 1'b0;
      check("b_done", b_done, 1);
      @(negedge clk);
      check("b_done_single", b_done, 0);
      check("b_post_busy", b_busy, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hv_class_reader.md
Name: hv_class_reader

Overview:
- Reader side of the continuous class memory.
- On a start pulse, snapshots the trained non-seizure and seizure class hypervectors (ns_hv, s_hv).
- Streams the snapshot out as fixed-width words over a valid/ready interface, for off-chip readback and for checkpointing trained models.
- Sits beside the generalized classifier, fed directly from its ns_hv/s_hv outputs.

Parameters:
- DIMENSIONS, 10000, hypervector width in bits.
- WORD_W, 32, output word width in bits; must be >= 16 when HV_CHECKSUM_EN is defined.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle request to snapshot and stream both class HVs
- ns_hv  input  DIMENSIONS  non-seizure class HV
- s_hv  input  DIMENSIONS  seizure class HV
- busy  output  1  high from the cycle after an accepted start until the done pulse
- out_data  output  WORD_W  current word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts the word when out_valid && out_ready
- out_sel  output  2  0 = NS word, 1 = S word, 2 = checksum word
- out_last  output  1  final word of the frame
- done  output  1  one-cycle pulse after the final handshake

Behaviour:
- WORDS = ceil(DIMENSIONS/WORD_W).
- Word k carries HV bits [k*WORD_W +: WORD_W], LSB word first.
- Bits beyond DIMENSIONS-1 in the last word read as 0.
- Frame order: NS words 0..WORDS-1, then S words 0..WORDS-1, then the optional checksum word.
- FSM states:
  - IDLE: start=1 copies ns_hv and s_hv into shadow registers and clears the word counter -> SEND_NS.
  - SEND_NS: on handshake, increment the counter; at WORDS-1, clear the counter -> SEND_S.
  - SEND_S: on handshake at WORDS-1 -> CHECK if HV_CHECKSUM_EN is defined, else -> FIN.
  - CHECK: on handshake -> FIN.
  - FIN: done=1 for one cycle -> IDLE.
- Latency: start accepted at cycle t gives busy=1 and out_valid=1 with NS word 0 at t+1.
- out_valid stays high in the SEND_* and CHECK states.
- Handshake stability: while out_valid && !out_ready, out_data, out_sel and out_last hold stable.
- The next word appears in the cycle after a handshake, so a continuously high out_ready gives one word per cycle.
- Inputs are sampled only at start; changes to ns_hv/s_hv during a frame do not affect the stream.
- start while busy (including the FIN cycle) is ignored; no queuing.
- out_last marks only the final word of the frame: S word WORDS-1, or the checksum word when enabled.
- Reset values: busy=0, out_valid=0, out_data=0, out_sel=0, out_last=0, done=0, FSM=IDLE, counter=0. Shadow registers are not reset.
- rst mid-frame returns to IDLE next cycle with out_valid=0; done is not pulsed.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: HV_CHECKSUM_EN.
- Defined:
  - Two popcount accumulators of width ceil(log2(DIMENSIONS+1)) count the set bits of each word at its handshake (NS and S separately).
  - One extra word is appended after the S words, with out_sel=2.
  - Word layout: NS popcount in bits [WORD_W/2-1:0], S popcount in bits [WORD_W-1:WORD_W/2], zero-extended.
  - Both accumulators clear on an accepted start.
- Undefined: no accumulators, no CHECK state, out_sel never equals 2. Frame is 2*WORDS words.

Decomposition:
- Package hv_reader_pkg:
  - state enum (IDLE, SEND_NS, SEND_S, CHECK, FIN)
  - out_sel encodings SEL_NS/SEL_S/SEL_CHK
  - function words_per_hv(DIMENSIONS, WORD_W)
  - function for the counter width.
- Sub-module hv_word_sel: combinational word-index extractor with zero padding, instantiated twice (NS, S).
- Popcount logic is a function in the package.

Test Plan:
- DIMENSIONS=10000, WORD_W=32, ns_hv all 0, s_hv all 1, out_ready=1:
  - 313 words 0x00000000 with sel=0.
  - 312 words 0xFFFFFFFF with sel=1.
  - Then 0x0000FFFF with sel=1, last=1.
  - done at handshake+1; 626 words total.
- DIMENSIONS=40, WORD_W=16, ns_hv=40'hA5_1234_5678:
  - NS words 0x5678, 0x1234, 0x00A5 (padding zero).
  - out_valid rises exactly 1 cycle after start.
- Random out_ready (50%): out_data/out_sel/out_last stable across every stalled cycle; word sequence identical to the no-stall run.
- start pulsed again at NS word 5 and ns_hv changed mid-frame: second start ignored, stream unchanged, exactly one done pulse.
- rst asserted at S word 10: next cycle out_valid=0, busy=0, no done. A new start streams from NS word 0.
- HV_CHECKSUM_EN, first vectors (ns all 0, s all 1, D=10000, W=32): 627th word 0x27100000, sel=2, last=1; S word 312 has last=0.
